// File: rtl/block_rom_arbiter.sv
// ---------------------------------------------------------------------------
// block_rom_arbiter
//
// Two-port read arbiter in front of three shared sprite colour-plane ROMs
// (R, G, B). Both ports share one address bus. At most one port is granted
// per cycle. The grant and the ROM address are registered on the same edge.
// rd_validN follows gntN one cycle later, which is when the ROM presents its
// registered output word.
//
// Arbitration: fixed priority, so port 0 wins a tie. When the optional
// ARB_STARVE_GUARD_EN macro is defined, a starvation counter forces a
// port 1 grant. This happens after port 1 has been denied STARVE_LIMIT
// consecutive times while requesting.
//
// Parameters
//   AW            sprite ROM address width
//   DW            width of one colour-plane ROM word
//   STARVE_LIMIT  denied cycles for port 1 before a forced grant (guard only)
//
// Ports
//   clk                          rising-edge clock
//   rst_n                        asynchronous active-low reset
//   req0 / addr0                 port 0 (stage renderer) request + address
//   req1 / addr1                 port 1 (sprite/HUD renderer) request + address
//   gnt0 / gnt1                  registered grants, one-hot or zero
//   rom_addr                     registered address to the R/G/B ROMs
//   rom_dataR/G/B                ROM outputs, one cycle after rom_addr
//   rd_data                      {rom_dataR, rom_dataG, rom_dataB}, combinational
//   rd_valid0 / rd_valid1        rd_data belongs to that port this cycle
//
// Configuration macro: ARB_STARVE_GUARD_EN
// ---------------------------------------------------------------------------
module block_rom_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic [AW-1:0]   addr0,
    input  logic            req1,
    input  logic [AW-1:0]   addr1,
    output logic            gnt0,
    output logic            gnt1,
    output logic [AW-1:0]   rom_addr,
    input  logic [DW-1:0]   rom_dataR,
    input  logic [DW-1:0]   rom_dataG,
    input  logic [DW-1:0]   rom_dataB,
    output logic [3*DW-1:0] rd_data,
    output logic            rd_valid0,
    output logic            rd_valid1
);

    logic          w_force1;
    logic          w_sel0;
    logic          w_sel1;
    logic [AW-1:0] w_addr_nxt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic [AW-1:0] r_rom_addr;
    logic          r_vld0;
    logic          r_vld1;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    // Port 1 is forced through once it has been denied STARVE_LIMIT times in a row
    assign w_force1 = req1 && (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Starvation counter: clears on a port 1 grant or an idle port 1; saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (!req1 || w_sel1) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`else
    assign w_force1 = 1'b0;
`endif

    // Grant selection and next ROM address; address holds when nobody is granted
    always_comb begin
        w_sel0     = 1'b0;
        w_sel1     = 1'b0;
        w_addr_nxt = r_rom_addr;
        if (w_force1) begin
            w_sel1     = 1'b1;
            w_addr_nxt = addr1;
        end else if (req0) begin
            w_sel0     = 1'b1;
            w_addr_nxt = addr0;
        end else if (req1) begin
            w_sel1     = 1'b1;
            w_addr_nxt = addr1;
        end else begin
            w_sel0     = 1'b0;
            w_sel1     = 1'b0;
        end
    end

    // Grant, address and valid pipeline; reset kills any in-flight valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rom_addr <= {AW{1'b0}};
            r_vld0     <= 1'b0;
            r_vld1     <= 1'b0;
        end else begin
            r_gnt0     <= w_sel0;
            r_gnt1     <= w_sel1;
            r_rom_addr <= w_addr_nxt;
            r_vld0     <= r_gnt0;
            r_vld1     <= r_gnt1;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rom_addr  = r_rom_addr;
    assign rd_valid0 = r_vld0;
    assign rd_valid1 = r_vld1;
    assign rd_data   = {rom_dataR, rom_dataG, rom_dataB};

endmodule

// File: tb/tb_block_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_block_rom_arbiter
//
// Self-checking bench for block_rom_arbiter with default parameters. It
// contains a registered ROM model and a directed vector table. It also runs
// hand-written sequences for starvation, asynchronous reset and reset
// release, followed by a randomised run against a reference model.
// ---------------------------------------------------------------------------
module tb_block_rom_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            req0;
    logic [AW-1:0]   addr0;
    logic            req1;
    logic [AW-1:0]   addr1;
    logic            gnt0;
    logic            gnt1;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_dataR;
    logic [DW-1:0]   rom_dataG;
    logic [DW-1:0]   rom_dataB;
    logic [3*DW-1:0] rd_data;
    logic            rd_valid0;
    logic            rd_valid1;

    int checks   = 0;
    int failures = 0;

    block_rom_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .req1      (req1),
        .addr1     (addr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rom_addr  (rom_addr),
        .rom_dataR (rom_dataR),
        .rom_dataG (rom_dataG),
        .rom_dataB (rom_dataB),
        .rd_data   (rd_data),
        .rd_valid0 (rd_valid0),
        .rd_valid1 (rd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, address-dependent word for each plane
    function automatic logic [3*DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [DW-1:0] wr;
        logic [DW-1:0] wg;
        logic [DW-1:0] wb;
        wr = 32'hA500_0000 | {25'd0, a};
        wg = 32'h00C3_0000 ^ ({25'd0, a} << 8);
        wb = ~{25'd0, a};
        return {wr, wg, wb};
    endfunction

    // Registered ROM model: output word appears one cycle after the address
    always_ff @(posedge clk) begin
        {rom_dataR, rom_dataG, rom_dataB} <= rom_word(rom_addr);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1);
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
    endtask

    typedef struct {
        logic          r0;
        logic [AW-1:0] a0;
        logic          r1;
        logic [AW-1:0] a1;
        logic          g0;
        logic          g1;
        logic [AW-1:0] ea;
        logic          v0;
        logic          v1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [AW-1:0] prev_ea;
        logic          pg0;
        logic          pg1;
        logic          eg0;
        logic          eg1;
        logic [AW-1:0] eaddr;
        logic [AW-1:0] paddr;
        logic          r0;
        logic          r1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        int            m_cnt;
        logic          force1;

        //            r0    a0      r1    a1      g0    g1    ea      v0    v1
        tbl[0]  = '{1'b1, 7'd33,  1'b0, 7'd0,   1'b1, 1'b0, 7'd33,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 7'd33,  1'b1, 1'b0};
        tbl[2]  = '{1'b1, 7'd5,   1'b1, 7'd70,  1'b1, 1'b0, 7'd5,   1'b0, 1'b0};
        tbl[3]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 7'd5,   1'b1, 1'b0};
        tbl[4]  = '{1'b0, 7'd0,   1'b1, 7'd10,  1'b0, 1'b1, 7'd10,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 7'd20,  1'b0, 7'd0,   1'b1, 1'b0, 7'd20,  1'b0, 1'b1};
        tbl[6]  = '{1'b0, 7'd0,   1'b1, 7'd127, 1'b0, 1'b1, 7'd127, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 7'd127, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 7'd127, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 7'd0,   1'b1, 7'd0,   1'b0, 1'b1, 7'd0,   1'b0, 1'b0};
        tbl[10] = '{1'b1, 7'd127, 1'b1, 7'd1,   1'b1, 1'b0, 7'd127, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 7'd0,   1'b0, 7'd0,   1'b0, 1'b0, 7'd127, 1'b1, 1'b0};

        // Reset state
        drive(1'b0, 7'd0, 1'b0, 7'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_async", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, 11'd0);
        tick();
        tick();
        chk("reset_held", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        prev_ea = 7'd0;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1);
            tick();
            chk($sformatf("vec%0d_ctl", i),
                {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr},
                {tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1, tbl[i].ea});
            if (tbl[i].v0 || tbl[i].v1) begin
                chk($sformatf("vec%0d_data", i), rd_data, rom_word(prev_ea));
            end
            prev_ea = tbl[i].ea;
        end

        // Contention held: eight port 0 grants then one port 1 (guard), or none
        drive(1'b1, 7'd3, 1'b1, 7'd99);
        for (int i = 1; i <= 27; i++) begin
            tick();
            if (GUARD && (i % 9 == 0)) begin
                chk($sformatf("starve%0d", i), {gnt0, gnt1, rom_addr}, {1'b0, 1'b1, 7'd99});
            end else begin
                chk($sformatf("starve%0d", i), {gnt0, gnt1, rom_addr}, {1'b1, 1'b0, 7'd3});
            end
        end
        drive(1'b0, 7'd0, 1'b0, 7'd0);
        tick();
        tick();

        // Asynchronous reset while gnt1 is high
        drive(1'b0, 7'd0, 1'b1, 7'd44);
        tick();
        chk("pre_rst_gnt1", {gnt0, gnt1, rom_addr}, {1'b0, 1'b1, 7'd44});
        drive(1'b0, 7'd0, 1'b0, 7'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, 11'd0);
        tick();
        chk("rst_hold", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, 11'd0);
        drive(1'b1, 7'd9, 1'b0, 7'd0);
        tick();
        chk("first_arb", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, {4'b1000, 7'd9});
        drive(1'b0, 7'd0, 1'b0, 7'd0);
        tick();
        chk("first_arb_vld", {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr}, {4'b0010, 7'd9});
        chk("first_arb_data", rd_data, rom_word(7'd9));

        // Fresh reset, then random traffic against a reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pg0   = 1'b0;
        pg1   = 1'b0;
        paddr = 7'd0;
        m_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            a0 = 7'($urandom_range(0, 127));
            a1 = 7'($urandom_range(0, 127));
            force1 = GUARD && r1 && (m_cnt == 8);
            eg1    = force1 || (!r0 && r1);
            eg0    = !force1 && r0;
            eaddr  = eg0 ? a0 : (eg1 ? a1 : paddr);
            if (!r1 || eg1) begin
                m_cnt = 0;
            end else if (m_cnt < 8) begin
                m_cnt = m_cnt + 1;
            end
            drive(r0, a0, r1, a1);
            tick();
            chk($sformatf("rand%0d_ctl", i),
                {gnt0, gnt1, rd_valid0, rd_valid1, rom_addr},
                {eg0, eg1, pg0, pg1, eaddr});
            if (pg0 || pg1) begin
                chk($sformatf("rand%0d_data", i), rd_data, rom_word(paddr));
            end
            pg0   = eg0;
            pg1   = eg1;
            paddr = eaddr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
